shift_reg_ctrl: RTL and testbench

- Command sequencer placed directly upstream of the 4-bit universal shift register.
- Accepts one command per valid/ready handshake: parallel load, shift right N times, shift left N times, or no-op.
- Drives the register's select lines (s1,s0), parallel word (i_par) and serial fill bits (msb, lsb) for the required number of cycles, then pulses done.
- Supports rotate by feeding the register's parallel output back into the serial inputs.

---
 rtl/shift_reg_ctrl.sv | 159 +++++++++++++++
 tb/tb_shift_reg_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_ctrl
// Brief    : Command sequencer driving a universal shift register's select,
//            parallel and serial-fill inputs (load / shift / rotate / nop).
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic             cmd_rot,
    input  logic [WIDTH-1:0] o_par_fb,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] i_par,
    output logic             msb,
    output logic             lsb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fill_q, fill_d;
    logic             rot_q, rot_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Outputs are computed for the state being entered, so select is valid
    // during the very cycle that state occupies.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        rot_d   = rot_q;
        sel_d   = 2'b00;
        par_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    cnt_d  = cmd_count;
                    fill_d = cmd_fill;
                    rot_d  = cmd_rot;
                    if (cmd_op == OP_LOAD) begin
                        state_d = LOAD;
                        sel_d   = OP_LOAD;
                        par_d   = cmd_data;
                        busy_d  = 1'b1;
                    end else if (cmd_op != OP_NOP && cmd_count != '0) begin
                        state_d = SHIFT;
                        sel_d   = cmd_op;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    sel_d  = op_q;
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            rot_q   <= 1'b0;
            sel_q   <= 2'b00;
            par_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            rot_q   <= rot_d;
            sel_q   <= sel_d;
            par_q   <= par_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Fill bits follow the live register output so a rotate wraps the bit
    // being shifted out in the same cycle.
    always_comb begin
        msb = 1'b0;
        lsb = 1'b0;
        if (state_q == SHIFT && op_q == OP_SHR) begin
            msb = rot_q ? o_par_fb[0] : fill_q;
        end
        if (state_q == SHIFT && op_q == OP_SHL) begin
            lsb = rot_q ? o_par_fb[WIDTH-1] : fill_q;
        end
    end

    // Only the end bits of the feedback word are needed.
    logic w_unused_fb;
    assign w_unused_fb = ^o_par_fb;

    assign cmd_ready = (state_q == IDLE);
    assign s1        = sel_q[1];
    assign s0        = sel_q[0];
    assign i_par     = par_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_reg_ctrl
// Brief    : Self-checking bench for shift_reg_ctrl with a downstream 4-bit
//            universal shift register model closing the feedback loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_reg_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             clear = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_count = '0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             cmd_fill = 1'b0;
    logic             cmd_rot = 1'b0;
    logic [WIDTH-1:0] reg_q = '0;
    logic             s1, s0, msb, lsb, busy, done;
    logic [WIDTH-1:0] i_par;
    logic [1:0]       sel;
    logic             preset_en = 1'b0;
    logic [WIDTH-1:0] preset_val = '0;

    assign sel = {s1, s0};

    shift_reg_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .cmd_fill  (cmd_fill),
        .cmd_rot   (cmd_rot),
        .o_par_fb  (reg_q),
        .s1        (s1),
        .s0        (s0),
        .i_par     (i_par),
        .msb       (msb),
        .lsb       (lsb),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Downstream universal shift register
    always @(posedge clk) begin
        if (preset_en) reg_q <= preset_val;
        else begin
            case (sel)
                2'b01:   reg_q <= {msb, reg_q[WIDTH-1:1]};
                2'b10:   reg_q <= {reg_q[WIDTH-2:0], lsb};
                2'b11:   reg_q <= i_par;
                default: reg_q <= reg_q;
            endcase
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [2:0] count;
        logic [3:0] data;
        logic       fill;
        logic       rot;
        logic [3:0] init;
        logic [3:0] exp_reg;
        int         exp_lat;
        int         exp_act;
    } vec_t;

    typedef struct {
        logic [3:0] exp_reg;
        int         exp_lat;
        int         exp_act;
    } exp_t;

    vec_t       vecs[10];
    exp_t       sb[$];
    logic [3:0] trace[0:31];
    int         n_cmp = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preset(input logic [3:0] v);
        @(negedge clk);
        preset_en  = 1'b1;
        preset_val = v;
        @(negedge clk);
        preset_en  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   lat, act, busy_n;
        bit   got_done;
        exp_t e;
        preset(v.init);
        cmd_op    = v.op;
        cmd_count = v.count;
        cmd_data  = v.data;
        cmd_fill  = v.fill;
        cmd_rot   = v.rot;
        cmd_valid = 1'b1;
        check($sformatf("v%0d ready_idle", idx), cmd_ready, 1);
        @(posedge clk);
        e.exp_reg = v.exp_reg;
        e.exp_lat = v.exp_lat;
        e.exp_act = v.exp_act;
        sb.push_back(e);
        lat = 0; act = 0; busy_n = 0; got_done = 0;
        for (int k = 1; k <= 20 && !got_done; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            trace[k] = reg_q;
            if (sel != 2'b00) act++;
            if (sel == 2'b11) check($sformatf("v%0d i_par", idx), i_par, v.data);
            if (busy) busy_n++;
            if (done) begin
                got_done = 1;
                lat = k;
            end
        end
        if (!got_done) begin
            check($sformatf("v%0d done_timeout", idx), 0, 1);
            void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            check($sformatf("v%0d scoreboard_empty", idx), 0, 1);
        end else begin
            e = sb.pop_front();
            check($sformatf("v%0d latency", idx), lat, e.exp_lat);
            check($sformatf("v%0d final_reg", idx), reg_q, e.exp_reg);
            check($sformatf("v%0d select_cycles", idx), act, e.exp_act);
            check($sformatf("v%0d busy_cycles", idx), busy_n, e.exp_act);
        end
        @(negedge clk);
        check($sformatf("v%0d done_one_cycle", idx), done, 0);
        check($sformatf("v%0d ready_after", idx), cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         first_load, shift_done, n_done, n_shr;
        logic [3:0] reg_at, reg_after;

        //             op     cnt   data     fill  rot   init     exp      lat act
        vecs[0] = '{2'b11, 3'd0, 4'b1010, 1'b0, 1'b0, 4'b0000, 4'b1010, 2, 1};
        vecs[1] = '{2'b10, 3'd3, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0111, 4, 3};
        vecs[2] = '{2'b01, 3'd4, 4'b0000, 1'b0, 1'b1, 4'b1001, 4'b1001, 5, 4};
        vecs[3] = '{2'b01, 3'd0, 4'b0000, 1'b1, 1'b0, 4'b0110, 4'b0110, 1, 0};
        vecs[4] = '{2'b00, 3'd5, 4'b1111, 1'b1, 1'b0, 4'b0110, 4'b0110, 1, 0};
        vecs[5] = '{2'b01, 3'd7, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 8, 7};
        vecs[6] = '{2'b10, 3'd2, 4'b0000, 1'b0, 1'b1, 4'b1000, 4'b0010, 3, 2};
        vecs[7] = '{2'b01, 3'd1, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b1000, 2, 1};
        vecs[8] = '{2'b11, 3'd7, 4'b0101, 1'b0, 1'b0, 4'b1111, 4'b0101, 2, 1};
        vecs[9] = '{2'b10, 3'd7, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b1111, 8, 7};

        // Reset and check idle outputs
        clear = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        check("rst ready", cmd_ready, 1);
        check("rst sel", sel, 0);
        check("rst i_par", i_par, 0);
        check("rst msb_lsb", {msb, lsb}, 0);
        check("rst busy_done", {busy, done}, 0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
            if (i == 1) begin
                check("shl trace2", trace[2], 4'b0001);
                check("shl trace3", trace[3], 4'b0011);
            end
            if (i == 2) begin
                check("ror trace2", trace[2], 4'b1100);
                check("ror trace3", trace[3], 4'b0110);
                check("ror trace4", trace[4], 4'b0011);
            end
        end

        // Back-pressure: a load held during a 5-cycle shift waits for IDLE
        preset(4'b1111);
        cmd_op = 2'b01; cmd_count = 3'd5; cmd_fill = 1'b0; cmd_rot = 1'b0;
        cmd_data = 4'b0000; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_op = 2'b11; cmd_data = 4'b1111; cmd_count = 3'd0;
        first_load = 0; shift_done = 0; n_done = 0; n_shr = 0;
        reg_at = 4'hx; reg_after = 4'hx;
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) @(negedge clk);
            if (sel == 2'b01) n_shr++;
            if (k == 3) check("bp ready_busy", cmd_ready, 0);
            if (done) begin
                n_done++;
                if (shift_done == 0) begin
                    shift_done = k;
                    reg_at = reg_q;
                end else reg_after = reg_q;
            end
            if (sel == 2'b11 && first_load == 0) begin
                first_load = k;
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        check("bp shift_cycles", n_shr, 5);
        check("bp shift_done_at", shift_done, 6);
        check("bp shift_result", reg_at, 4'b0000);
        check("bp load_at", first_load, 8);
        check("bp load_result", reg_after, 4'b1111);
        check("bp done_count", n_done, 2);

        // Asynchronous reset in the middle of a count=6 shift
        preset(4'b0000);
        cmd_op = 2'b10; cmd_count = 3'd6; cmd_fill = 1'b1; cmd_rot = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("ar sel_before", sel, 2'b10);
        #2 clear = 1'b0;
        #1;
        check("ar sel_forced", sel, 0);
        check("ar busy_done", {busy, done}, 0);
        check("ar msb_lsb", {msb, lsb}, 0);
        check("ar ready", cmd_ready, 1);
        check("ar reg_partial", reg_q, 4'b0001);
        repeat (2) @(negedge clk);
        clear = 1'b1;
        n_done = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("ar no_done", n_done, 0);
        check("ar reg_held", reg_q, 4'b0001);
        run_vec(vecs[0], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
